vga_stream_out: RTL and testbench
=================================

VGA_STREAM_OUT -- requirements
Module: vga_stream_out

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- COLOR_W, 12: RGB pixel width.
- HD/HF/HR/HB, 1280/48/112/248: horizontal display, front porch, sync, back porch, in clocks.
- VD/VF/VR/VB, 1024/1/3/38: vertical display, front porch, sync, back porch, in lines.
- HS_POL/VS_POL, 1/1: active level of hsync/vsync.
- FIFO_DEPTH, 16: pixel FIFO entries, power of 2, minimum 4.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: sole clock.
- arst, in, 1: asynchronous, active-high reset.
- en_i, in, 1: timing enable.
- pix_data_i, in, COLOR_W: pixel colour.
- pix_sof_i, in, 1: marks the first pixel of a frame.
- pix_valid_i, in, 1: pixel offered.
- pix_ready_o, out, 1: pixel accepted when pix_valid_i is also high.
- clr_underflow_i, in, 1: clears underflow_o.
- hsync_o, out, 1: horizontal sync.
- vsync_o, out, 1: vertical sync.
- de_o, out, 1: display enable.
- x_o, out, $clog2(HD): display column.
- y_o, out, $clog2(VD): display row.
- rgb_o, out, COLOR_W: pixel out.
- frame_start_o, out, 1: pulse at pixel (0,0).
- underflow_o, out, 1: sticky FIFO-empty-during-display flag.

Function
REQ-003 Horizontal counter hc SHALL run 0..HTOT-1 (HTOT=HD+HF+HR+HB) and wrap to 0; the vertical counter vc SHALL increment on hc wrap, over 0..VTOT-1.
REQ-004 Region order SHALL be display, front porch, sync, back porch: hsync is active for HD+HF <= hc < HD+HF+HR, and the vsync rule is analogous.
REQ-005 Display is active when hc<HD and vc<VD.
REQ-006 hsync_o, vsync_o, de_o, x_o, y_o, rgb_o and frame_start_o SHALL be registered, with exactly 1 clk latency from the counter state and mutual alignment.
REQ-007 x_o/y_o SHALL equal hc/vc while de_o=1 and SHALL be 0 otherwise.
REQ-008 frame_start_o SHALL be high for exactly the one cycle with de_o=1 at x=0, y=0.
REQ-009 When en_i=0, the counters SHALL synchronously clear to 0 and hold. Sync outputs SHALL be inactive (NOT HS_POL / NOT VS_POL), de_o=0, and rgb_o=0. The FIFO SHALL still accept data.
REQ-010 Deasserting en_i mid-frame SHALL abort the frame. On re-enable, timing SHALL restart at hc=vc=0.
REQ-011 The FIFO SHALL store {sof, data}. pix_ready_o = NOT full, combinational from FIFO state. A push occurs iff pix_valid_i AND pix_ready_o.
REQ-012 Pop rules, applied in display cycles only:
- Head without sof: pop the entry and output its data.
- Head with sof at (0,0): pop the entry and output its data.
- Head with sof elsewhere: hold the entry (no pop) and output 0, realigning to the next frame.
- At (0,0) with a non-sof head: pop the entry and output its data.
REQ-013 In a display cycle with the FIFO empty, the block SHALL output rgb_o=0 and set underflow_o, with no bypass of the same-cycle push.
REQ-014 underflow_o SHALL stay set until clr_underflow_i=1. If set and clear occur in the same cycle, set SHALL win.
REQ-015 Push and pop in the same cycle SHALL leave the occupancy unchanged. A push at full is impossible because pix_ready_o=0.
REQ-016 Non-display cycles SHALL output rgb_o=0.

Reset
REQ-017 While arst=1, regardless of clk:
- hc=vc=0 and the FIFO is empty.
- Sync outputs are inactive, de_o=0, x_o=y_o=0, rgb_o=0.
- frame_start_o=0 and underflow_o=0.
- pix_ready_o=1.
REQ-018 Reset mid-frame SHALL discard FIFO contents. After release, the first clk edge SHALL begin at hc=vc=0 if en_i=1.

Structure
REQ-019 Package vga_pkg SHALL hold the timing default localparams, the HTOT/VTOT computation function, and the counter-width localparams.
REQ-020 Counters and sync generation SHALL reside in the sub-module vga_timing. The FIFO and pixel alignment SHALL be in vga_stream_out.

Verification
REQ-021 Tiny timing (HD=4,HF=1,HR=2,HB=1,VD=3,VF=1,VR=1,VB=1), en_i=1, FIFO pre-filled:
- hsync_o active exactly at hc 5..6.
- de_o high 4 cycles per line, 3 lines per frame.
- frame period 8x6=48 clks.
REQ-022 HS_POL=0, VS_POL=0, en_i=0 -> hsync_o=vsync_o=1, de_o=0, rgb_o=0 constantly.
REQ-023 Stream 12 pixels with values 1..12, sof on value 1, tiny timing -> rgb_o shows 1..4, 5..8, 9..12 on lines 0..2, and frame_start_o coincides with value 1.
REQ-024 Starve the FIFO after 6 pixels -> rgb_o=0 from pixel 7 onward and underflow_o=1 until clr_underflow_i. A simultaneous clear and new underflow leaves underflow_o=1.
REQ-025 Push a sof pixel (value 0xABC) mid-frame -> it is held, rgb_o=0 for the rest of the frame, and 0xABC appears with frame_start_o in the next frame.
REQ-026 Fill FIFO_DEPTH entries with en_i=0 -> pix_ready_o=0. Assert arst mid-frame -> all outputs hit reset values asynchronously, and pix_ready_o=1.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: default VGA timing, total-period and counter-width helpers shared by the video path.
package vga_pkg;

   localparam int DEF_HD = 1280;
   localparam int DEF_HF = 48;
   localparam int DEF_HR = 112;
   localparam int DEF_HB = 248;
   localparam int DEF_VD = 1024;
   localparam int DEF_VF = 1;
   localparam int DEF_VR = 3;
   localparam int DEF_VB = 38;

   function automatic int total(input int d, input int f, input int r, input int b);
      return d + f + r + b;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_HTOT = total(DEF_HD, DEF_HF, DEF_HR, DEF_HB);
   localparam int DEF_VTOT = total(DEF_VD, DEF_VF, DEF_VR, DEF_VB);
   localparam int DEF_HC_W = cnt_w(DEF_HTOT);
   localparam int DEF_VC_W = cnt_w(DEF_VTOT);

endpackage

// File: rtl/vga_timing.sv
// vga_timing: horizontal/vertical counters with sync and display-region decode of the current position.
module vga_timing
   import vga_pkg::*;
#(
   parameter int HD     = DEF_HD,
   parameter int HF     = DEF_HF,
   parameter int HR     = DEF_HR,
   parameter int HB     = DEF_HB,
   parameter int VD     = DEF_VD,
   parameter int VF     = DEF_VF,
   parameter int VR     = DEF_VR,
   parameter int VB     = DEF_VB,
   parameter bit HS_POL = 1'b1,
   parameter bit VS_POL = 1'b1,
   parameter int HC_W   = cnt_w(total(HD, HF, HR, HB)),
   parameter int VC_W   = cnt_w(total(VD, VF, VR, VB))
) (
   input  logic            clk,
   input  logic            arst,
   input  logic            en_i,
   output logic [HC_W-1:0] hc_o,
   output logic [VC_W-1:0] vc_o,
   output logic            disp_o,
   output logic            at00_o,
   output logic            hsync_o,
   output logic            vsync_o
);

   localparam int HTOT = total(HD, HF, HR, HB);
   localparam int VTOT = total(VD, VF, VR, VB);

   logic [HC_W-1:0] hc_q, hc_d;
   logic [VC_W-1:0] vc_q, vc_d;
   logic            h_end, v_end, h_sync, v_sync;

   always_comb begin
      h_end = hc_q == HC_W'(HTOT - 1);
      v_end = vc_q == VC_W'(VTOT - 1);
      hc_d  = (!en_i || h_end) ? '0 : hc_q + HC_W'(1);
      vc_d  = !en_i ? '0 : !h_end ? vc_q : v_end ? '0 : vc_q + VC_W'(1);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         hc_q <= '0;
         vc_q <= '0;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
      end
   end

   // Disabled timing reports no display and inactive sync regardless of counter state.
   always_comb begin
      h_sync  = (hc_q >= HC_W'(HD + HF)) && (hc_q < HC_W'(HD + HF + HR));
      v_sync  = (vc_q >= VC_W'(VD + VF)) && (vc_q < VC_W'(VD + VF + VR));
      hc_o    = hc_q;
      vc_o    = vc_q;
      disp_o  = en_i && (hc_q < HC_W'(HD)) && (vc_q < VC_W'(VD));
      at00_o  = (hc_q == '0) && (vc_q == '0);
      hsync_o = (en_i && h_sync) ? HS_POL : !HS_POL;
      vsync_o = (en_i && v_sync) ? VS_POL : !VS_POL;
   end

endmodule

// File: rtl/vga_stream_out.sv
// vga_stream_out: pixel FIFO feeding a VGA raster, realigning frames on sof and flagging underflow.
module vga_stream_out
   import vga_pkg::*;
#(
   parameter int COLOR_W    = 12,
   parameter int HD         = DEF_HD,
   parameter int HF         = DEF_HF,
   parameter int HR         = DEF_HR,
   parameter int HB         = DEF_HB,
   parameter int VD         = DEF_VD,
   parameter int VF         = DEF_VF,
   parameter int VR         = DEF_VR,
   parameter int VB         = DEF_VB,
   parameter bit HS_POL     = 1'b1,
   parameter bit VS_POL     = 1'b1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  en_i,
   input  logic [COLOR_W-1:0]    pix_data_i,
   input  logic                  pix_sof_i,
   input  logic                  pix_valid_i,
   output logic                  pix_ready_o,
   input  logic                  clr_underflow_i,
   output logic                  hsync_o,
   output logic                  vsync_o,
   output logic                  de_o,
   output logic [$clog2(HD)-1:0] x_o,
   output logic [$clog2(VD)-1:0] y_o,
   output logic [COLOR_W-1:0]    rgb_o,
   output logic                  frame_start_o,
   output logic                  underflow_o
);

   localparam int HC_W = cnt_w(total(HD, HF, HR, HB));
   localparam int VC_W = cnt_w(total(VD, VF, VR, VB));
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int XW   = $clog2(HD);
   localparam int YW   = $clog2(VD);
   localparam logic [AW:0] P_ONE = (AW + 1)'(1);

   typedef struct packed {
      logic               sof;
      logic [COLOR_W-1:0] data;
   } ent_t;

   logic [HC_W-1:0] hc;
   logic [VC_W-1:0] vc;
   logic            disp, at00, hs, vs;

   vga_timing #(
      .HD(HD), .HF(HF), .HR(HR), .HB(HB),
      .VD(VD), .VF(VF), .VR(VR), .VB(VB),
      .HS_POL(HS_POL), .VS_POL(VS_POL),
      .HC_W(HC_W), .VC_W(VC_W)
   ) u_timing (
      .clk    (clk),
      .arst   (arst),
      .en_i   (en_i),
      .hc_o   (hc),
      .vc_o   (vc),
      .disp_o (disp),
      .at00_o (at00),
      .hsync_o(hs),
      .vsync_o(vs)
   );

   ent_t        mem [FIFO_DEPTH];
   ent_t        head;
   logic [AW:0] wp_q, wp_d, rp_q, rp_d;
   logic        empty, full, push, pop;

   // A sof entry only leaves the FIFO at (0,0); elsewhere it blocks so the stream realigns to the next frame.
   always_comb begin
      empty = wp_q == rp_q;
      full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
      head  = mem[rp_q[AW-1:0]];
      push  = pix_valid_i && !full;
      pop   = disp && !empty && (!head.sof || at00);
      wp_d  = push ? wp_q + P_ONE : wp_q;
      rp_d  = pop ? rp_q + P_ONE : rp_q;
   end

   assign pix_ready_o = !full;

   always_ff @(posedge clk) begin
      if (push) mem[wp_q[AW-1:0]] <= '{sof: pix_sof_i, data: pix_data_i};
   end

   logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, uf_q, uf_d;
   logic [XW-1:0]      x_q, x_d;
   logic [YW-1:0]      y_q, y_d;
   logic [COLOR_W-1:0] rgb_q, rgb_d;

   always_comb begin
      hs_d  = hs;
      vs_d  = vs;
      de_d  = disp;
      x_d   = disp ? hc[XW-1:0] : '0;
      y_d   = disp ? vc[YW-1:0] : '0;
      rgb_d = pop ? head.data : '0;
      fs_d  = disp && at00;
      uf_d  = (disp && empty) || (uf_q && !clr_underflow_i);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         hs_q  <= !HS_POL;
         vs_q  <= !VS_POL;
         de_q  <= 1'b0;
         x_q   <= '0;
         y_q   <= '0;
         rgb_q <= '0;
         fs_q  <= 1'b0;
         uf_q  <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         de_q  <= de_d;
         x_q   <= x_d;
         y_q   <= y_d;
         rgb_q <= rgb_d;
         fs_q  <= fs_d;
         uf_q  <= uf_d;
      end
   end

   assign hsync_o       = hs_q;
   assign vsync_o       = vs_q;
   assign de_o          = de_q;
   assign x_o           = x_q;
   assign y_o           = y_q;
   assign rgb_o         = rgb_q;
   assign frame_start_o = fs_q;
   assign underflow_o   = uf_q;

endmodule

// File: tb/tb_vga_stream_out.sv
// tb_vga_stream_out: tiny-timing raster with a frame-position/queue reference model, plus an inverted-polarity idle instance.
module tb_vga_stream_out;

   localparam int HD = 4, HF = 1, HR = 2, HB = 1;
   localparam int VD = 3, VF = 1, VR = 1, VB = 1;
   localparam int HTOT = HD + HF + HR + HB;
   localparam int VTOT = VD + VF + VR + VB;
   localparam int DEPTH = 16;

   logic        clk = 1'b0, arst = 1'b1, en_i = 1'b0;
   logic        pix_sof_i = 1'b0, pix_valid_i = 1'b0, clr_underflow_i = 1'b0;
   logic [11:0] pix_data_i = '0;
   logic        pix_ready_o, hsync_o, vsync_o, de_o, frame_start_o, underflow_o;
   logic [1:0]  x_o, y_o;
   logic [11:0] rgb_o;
   logic        n_ready, n_hs, n_vs, n_de, n_fs, n_uf;
   logic [1:0]  n_x, n_y;
   logic [11:0] n_rgb;

   vga_stream_out #(
      .COLOR_W(12), .HD(HD), .HF(HF), .HR(HR), .HB(HB),
      .VD(VD), .VF(VF), .VR(VR), .VB(VB),
      .HS_POL(1'b1), .VS_POL(1'b1), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .arst(arst), .en_i(en_i),
      .pix_data_i(pix_data_i), .pix_sof_i(pix_sof_i), .pix_valid_i(pix_valid_i),
      .pix_ready_o(pix_ready_o), .clr_underflow_i(clr_underflow_i),
      .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .x_o(x_o), .y_o(y_o),
      .rgb_o(rgb_o), .frame_start_o(frame_start_o), .underflow_o(underflow_o)
   );

   vga_stream_out #(
      .COLOR_W(12), .HD(HD), .HF(HF), .HR(HR), .HB(HB),
      .VD(VD), .VF(VF), .VR(VR), .VB(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .FIFO_DEPTH(DEPTH)
   ) dut_neg (
      .clk(clk), .arst(arst), .en_i(1'b0),
      .pix_data_i(12'h0), .pix_sof_i(1'b0), .pix_valid_i(1'b0),
      .pix_ready_o(n_ready), .clr_underflow_i(1'b0),
      .hsync_o(n_hs), .vsync_o(n_vs), .de_o(n_de), .x_o(n_x), .y_o(n_y),
      .rgb_o(n_rgb), .frame_start_o(n_fs), .underflow_o(n_uf)
   );

   always #5 clk = ~clk;

   int          checks = 0, errors = 0;
   int          t = 0;
   logic        uf_m = 1'b0;
   logic [12:0] q[$];
   logic        e_hs, e_vs, e_de, e_fs;
   int          e_x, e_y;
   logic [11:0] e_rgb, fs_rgb;
   int          de_cnt, hs_cnt, fs_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_reset();
      chk("rst_hsync", hsync_o, 0);
      chk("rst_vsync", vsync_o, 0);
      chk("rst_de", de_o, 0);
      chk("rst_x", x_o, 0);
      chk("rst_y", y_o, 0);
      chk("rst_rgb", rgb_o, 0);
      chk("rst_fs", frame_start_o, 0);
      chk("rst_uf", underflow_o, 0);
      chk("rst_ready", pix_ready_o, 1);
   endtask

   task automatic check_neg();
      chk("neg_hsync", n_hs, 1);
      chk("neg_vsync", n_vs, 1);
      chk("neg_de", n_de, 0);
      chk("neg_rgb", n_rgb, 0);
   endtask

   task automatic model_reset();
      q.delete();
      t = 0;
      uf_m = 1'b0;
   endtask

   task automatic do_reset();
      en_i = 1'b0; pix_valid_i = 1'b0; pix_sof_i = 1'b0; clr_underflow_i = 1'b0;
      arst = 1'b1;
      @(negedge clk);
      expect_reset();
      check_neg();
      arst = 1'b0;
      model_reset();
   endtask

   // Reference: position within the frame is t (cycles since enable), pixels live in a queue.
   task automatic step(input logic en, input logic v, input logic s, input logic [11:0] d, input logic clr);
      int   hc, vc;
      logic disp, set, ok;
      en_i = en; pix_valid_i = v; pix_sof_i = s; pix_data_i = d; clr_underflow_i = clr;
      ok = q.size() < DEPTH;
      chk("ready", pix_ready_o, ok);
      hc = t % HTOT;
      vc = t / HTOT;
      disp = en && hc < HD && vc < VD;
      e_hs = en && hc >= HD + HF && hc < HD + HF + HR;
      e_vs = en && vc >= VD + VF && vc < VD + VF + VR;
      e_de = disp;
      e_x = disp ? hc : 0;
      e_y = disp ? vc : 0;
      e_fs = disp && t == 0;
      e_rgb = '0;
      set = 1'b0;
      if (disp) begin
         if (q.size() == 0) set = 1'b1;
         else if (!q[0][12] || t == 0) begin
            e_rgb = q[0][11:0];
            void'(q.pop_front());
         end
      end
      if (v && ok) q.push_back({s, d});
      uf_m = set || (uf_m && !clr);
      t = en ? (t + 1) % (HTOT * VTOT) : 0;
      @(posedge clk);
      @(negedge clk);
      chk("hsync", hsync_o, e_hs);
      chk("vsync", vsync_o, e_vs);
      chk("de", de_o, e_de);
      chk("x", x_o, e_x);
      chk("y", y_o, e_y);
      chk("rgb", rgb_o, e_rgb);
      chk("frame_start", frame_start_o, e_fs);
      chk("underflow", underflow_o, uf_m);
      check_neg();
      if (de_o) de_cnt++;
      if (hsync_o) hs_cnt++;
      if (frame_start_o) begin
         fs_cnt++;
         fs_rgb = rgb_o;
      end
   endtask

   initial begin
      @(negedge clk);
      expect_reset();
      check_neg();
      arst = 1'b0;

      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 12'($urandom), 1'b0);
      chk("full_ready", pix_ready_o, 0);
      step(1'b0, 1'b1, 1'b0, 12'h5A5, 1'b0);
      de_cnt = 0; hs_cnt = 0; fs_cnt = 0;
      for (int i = 0; i < HTOT * VTOT; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 12'($urandom), 1'b0);
      chk("de_per_frame", de_cnt, HD * VD);
      chk("hs_per_frame", hs_cnt, HR * VTOT);
      chk("fs_per_frame", fs_cnt, 1);

      do_reset();
      for (int i = 1; i <= 12; i++) step(1'b0, 1'b1, i == 1, 12'(i), 1'b0);
      fs_cnt = 0; fs_rgb = '0;
      for (int i = 0; i < HTOT * VTOT; i++) step(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
      chk("fs_rgb_first", fs_rgb, 1);
      chk("fs_count", fs_cnt, 1);

      do_reset();
      for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, i == 1, 12'(i + 32), 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b0, 1'b0, 12'h0, i == 11 || i == 20);
         if (i == 11) chk("uf_set_wins", underflow_o, 1);
         if (i == 20) chk("uf_cleared", underflow_o, 0);
      end

      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 12'($urandom_range(1, 4095)), 1'b0);
      fs_cnt = 0; fs_rgb = '0;
      for (int i = 0; i < HTOT * VTOT + 2; i++) step(1'b1, i == 5, i == 5, 12'hABC, 1'b0);
      chk("sof_realign", fs_rgb, 12'hABC);
      chk("fs_count2", fs_cnt, 2);

      do_reset();
      for (int i = 0; i < 1500; i++)
         step(1'($urandom_range(0, 99) < 97), 1'($urandom_range(0, 99) < 70),
              1'($urandom_range(0, 99) < 5), 12'($urandom), 1'($urandom_range(0, 99) < 5));

      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 12'($urandom_range(1, 4095)), 1'b0);
      chk("full_ready2", pix_ready_o, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
      chk("pre_rst_de", de_o, 1);
      #2 arst = 1'b1;
      #1 expect_reset();
      check_neg();
      @(negedge clk);
      expect_reset();
      arst = 1'b0;
      model_reset();
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
